// File: rtl/program_sequencer_if.sv
// Program sequencer bus: decoder/ALU requests into the sequencer and
// fetch address, program counter and status back out.
// master = instruction decoder side, slave = sequencer side.
interface program_sequencer_if;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jump_addr;
    logic       dont_jmp;
    logic       hold;
    logic       call;
    logic       ret;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic       stack_err;
    logic [7:0] from_PS;

    modport master (
        output jmp, jmp_nz, jump_addr, dont_jmp, hold, call, ret,
        input  pm_addr, pc, stack_err, from_PS
    );

    modport slave (
        input  jmp, jmp_nz, jump_addr, dont_jmp, hold, call, ret,
        output pm_addr, pc, stack_err, from_PS
    );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: selects the next program-memory fetch address by
// strict priority (reset, hold, jmp, taken jmp_nz, call, ret, increment),
// registers it as the program counter and counts taken redirects.
// Optional feature macro: SEQ_CALL_STACK_EN builds a 4-deep call/return
// stack with a sticky overflow/underflow flag. Without it, call and ret
// are ignored and stack_err is tied low.
module program_sequencer (
    input  logic               clk,
    input  logic               sync_reset,
    program_sequencer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [7:0] from_ps_q;
    logic [7:0] from_ps_d;
    logic [7:0] pm_addr_s;
    logic [7:0] pc_inc_s;
    logic [7:0] jump_tgt_s;
    logic       redirect_s;
    logic       frozen_s;

`ifdef SEQ_CALL_STACK_EN
    logic [7:0] stack_q [4];
    logic [7:0] stack_d [4];
    logic [2:0] depth_q;
    logic [2:0] depth_d;
    logic       stack_err_q;
    logic       stack_err_d;
`else
    logic       unused_call_ret_s;
    assign unused_call_ret_s = bus.call ^ bus.ret;
`endif

    // Stall FSM: a hold cycle freezes fetch; redirects seen while frozen are dropped, not queued
    always_comb begin
        state_d  = state_q;
        frozen_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                frozen_s = bus.hold;
                if (bus.hold) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                frozen_s = bus.hold;
                if (bus.hold) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                frozen_s = bus.hold;
                state_d  = ST_RUN;
            end
        endcase
    end

    // Fetch address priority select plus next-state for pc, redirect count and call stack
    always_comb begin
        pc_inc_s   = pc_q + 8'd1;
        jump_tgt_s = {bus.jump_addr, 4'h0};
        pm_addr_s  = pc_inc_s;
        redirect_s = 1'b0;
`ifdef SEQ_CALL_STACK_EN
        stack_d     = stack_q;
        depth_d     = depth_q;
        stack_err_d = stack_err_q;
`endif
        if (sync_reset) begin
            pm_addr_s = 8'h00;
        end else if (frozen_s) begin
            pm_addr_s = pc_q;
        end else if (bus.jmp) begin
            pm_addr_s  = jump_tgt_s;
            redirect_s = 1'b1;
        end else if (bus.jmp_nz && !bus.dont_jmp) begin
            pm_addr_s  = jump_tgt_s;
            redirect_s = 1'b1;
`ifdef SEQ_CALL_STACK_EN
        end else if (bus.call) begin
            // A full stack still redirects; only the push is lost
            pm_addr_s  = jump_tgt_s;
            redirect_s = 1'b1;
            if (depth_q == 3'd4) begin
                stack_err_d = 1'b1;
            end else begin
                stack_d[depth_q[1:0]] = pc_inc_s;
                depth_d               = depth_q + 3'd1;
            end
        end else if (bus.ret) begin
            // Empty stack: fall through to increment and flag the underflow
            if (depth_q != 3'd0) begin
                pm_addr_s  = stack_q[depth_q[1:0] - 2'd1];
                redirect_s = 1'b1;
                depth_d    = depth_q - 3'd1;
            end else begin
                pm_addr_s   = pc_inc_s;
                stack_err_d = 1'b1;
            end
`endif
        end else begin
            pm_addr_s = pc_inc_s;
        end

        pc_d = pm_addr_s;
        if (redirect_s) begin
            from_ps_d = from_ps_q + 8'd1;
        end else begin
            from_ps_d = from_ps_q;
        end
    end

    // Program counter, redirect counter and FSM state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q      <= 8'h00;
            from_ps_q <= 8'h00;
            state_q   <= ST_RUN;
        end else begin
            pc_q      <= pc_d;
            from_ps_q <= from_ps_d;
            state_q   <= state_d;
        end
    end

`ifdef SEQ_CALL_STACK_EN
    // Stack depth and sticky error flag; reset empties the stack logically
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            depth_q     <= 3'd0;
            stack_err_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Stack storage: contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            stack_q[i] <= stack_d[i];
        end
    end

    assign bus.stack_err = stack_err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.pm_addr = pm_addr_s;
    assign bus.pc      = pc_q;
    assign bus.from_PS = from_ps_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a vector table for the main
// fetch/redirect/hold behaviour, then hand-written multi-cycle sequences.
// Call-stack sequences are compiled when SEQ_CALL_STACK_EN is defined;
// otherwise the bench checks that call/ret are ignored.
module tb_program_sequencer;

    logic clk;
    logic sync_reset;
    int   checks;
    int   errors;
    logic [7:0] exp_q [$];

    program_sequencer_if bus_if ();

    program_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hold;
        logic       jmp;
        logic       jmp_nz;
        logic       dont_jmp;
        logic [3:0] ja;
        logic [7:0] exp_pm;
        logic [7:0] exp_pc;
        logic [7:0] exp_fps;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected fetch address, compare it
    // at the falling edge and return just after the next rising edge.
    task automatic step(input logic rst, input logic h, input logic j, input logic jnz,
                        input logic dj, input logic [3:0] ja, input logic c, input logic r,
                        input logic [7:0] exp_pm, input string nm);
        logic [7:0] want;
        sync_reset       = rst;
        bus_if.hold      = h;
        bus_if.jmp       = j;
        bus_if.jmp_nz    = jnz;
        bus_if.dont_jmp  = dj;
        bus_if.jump_addr = ja;
        bus_if.call      = c;
        bus_if.ret       = r;
        exp_q.push_back(exp_pm);
        @(negedge clk);
        want = exp_q.pop_front();
        check(nm, bus_if.pm_addr, want);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] exp_pm, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, exp_pm, nm);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sync_reset       = 1'b1;
        bus_if.hold      = 1'b0;
        bus_if.jmp       = 1'b0;
        bus_if.jmp_nz    = 1'b0;
        bus_if.dont_jmp  = 1'b0;
        bus_if.jump_addr = 4'h0;
        bus_if.call      = 1'b0;
        bus_if.ret       = 1'b0;

        //            rst   hold  jmp   jnz   dj    ja    pm     pc     fps
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 8'h00, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h02, 8'h01, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h03, 8'h02, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h20, 8'h03, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h21, 8'h20, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 8'h22, 8'h21, 8'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 8'h70, 8'h22, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h71, 8'h70, 8'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 8'h71, 8'h71, 8'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h71, 8'h71, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h72, 8'h71, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'hF0, 8'h72, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'hF0, 8'hF0, 8'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'hF1, 8'hF0, 8'd4};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 8'h00, 8'hF1, 8'd4};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 8'h00, 8'd0};

        // initial reset
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, "reset_pm");
        check("reset_pc", bus_if.pc, 8'h00);
        check("reset_from_ps", bus_if.from_PS, 8'h00);
        check("reset_stack_err", {7'd0, bus_if.stack_err}, 8'h00);

        // vector table
        for (int i = 0; i < 17; i++) begin
            check($sformatf("vec%0d_pc", i), bus_if.pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_from_ps", i), bus_if.from_PS, vecs[i].exp_fps);
            step(vecs[i].rst, vecs[i].hold, vecs[i].jmp, vecs[i].jmp_nz, vecs[i].dont_jmp,
                 vecs[i].ja, 1'b0, 1'b0, vecs[i].exp_pm, $sformatf("vec%0d_pm", i));
        end

        // jmp from pc 25 to page A
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, "s33_rst");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 8'h20, "s33_jmp20");
        for (int k = 1; k <= 5; k++) idle(8'h20 + 8'(k), "s33_inc");
        check("s33_pc25", bus_if.pc, 8'h25);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 8'hA0, "s33_jmpA0");
        check("s33_pcA0", bus_if.pc, 8'hA0);
        check("s33_from_ps", bus_if.from_PS, 8'd2);

        // jmp_nz from pc 30, suppressed then taken
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 8'h30, "s34_jmp30");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 8'h31, "s34_nz_untaken");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 8'h30, "s34_jmp30b");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 8'h70, "s34_nz_taken");
        check("s34_from_ps", bus_if.from_PS, 8'd5);

        // hold at pc 12 with a jmp pulse mid-hold
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 8'h10, "s35_jmp10");
        idle(8'h11, "s35_inc11");
        idle(8'h12, "s35_inc12");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h12, "s35_hold1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 8'h12, "s35_hold2_jmp");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h12, "s35_hold3");
        idle(8'h13, "s35_release");
        check("s35_from_ps", bus_if.from_PS, 8'd6);

        // 8-bit pc wrap
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 8'hF0, "wrap_jmpF0");
        for (int k = 1; k <= 15; k++) idle(8'hF0 + 8'(k), "wrap_inc");
        check("wrap_pcFF", bus_if.pc, 8'hFF);
        idle(8'h00, "wrap_pm00");
        check("wrap_pc00", bus_if.pc, 8'h00);

`ifdef SEQ_CALL_STACK_EN
        // single call/ret
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, "cs_rst");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 8'h10, "cs_jmp10");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 8'h40, "cs_call40");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h11, "cs_ret11");
        check("cs_from_ps3", bus_if.from_PS, 8'd3);
        check("cs_err0", {7'd0, bus_if.stack_err}, 8'h00);
        // five nested calls, fifth overflows
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 8'h10, "cs_n1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 8'h20, "cs_n2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 8'h30, "cs_n3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 8'h40, "cs_n4");
        check("cs_err_before_ovf", {7'd0, bus_if.stack_err}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 8'h50, "cs_n5_ovf");
        check("cs_err_ovf", {7'd0, bus_if.stack_err}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h31, "cs_r1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h21, "cs_r2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h11, "cs_r3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h12, "cs_r4");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h13, "cs_r5_underflow");
        check("cs_from_ps12", bus_if.from_PS, 8'd12);
        check("cs_err_sticky", {7'd0, bus_if.stack_err}, 8'h01);
        // call and ret together act as call
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 1'b1, 8'h80, "cs_callret");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h14, "cs_ret14");
        // reset mid call sequence
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, "cs_rst2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 8'h60, "cs_call60");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 8'h00, "cs_rst_call");
        check("cs_rst_err", {7'd0, bus_if.stack_err}, 8'h00);
        check("cs_rst_from_ps", bus_if.from_PS, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h01, "cs_ret_depth0");
        check("cs_underflow_err", {7'd0, bus_if.stack_err}, 8'h01);
        check("cs_underflow_from_ps", bus_if.from_PS, 8'd0);
`else
        // call/ret are ignored without the stack
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, "ns_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 8'h01, "ns_call");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h02, "ns_ret");
        check("ns_err", {7'd0, bus_if.stack_err}, 8'h00);
        check("ns_from_ps", bus_if.from_PS, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and sync_reset; all state changes on rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 sync_reset  input  1  synchronous active-high reset.
REQ-004 jmp  input  1  unconditional jump request from instruction decoder.
REQ-005 jmp_nz  input  1  conditional jump request, taken only when dont_jmp = 0.
REQ-006 jump_addr  input  4  target page (decoder ir_nibble); jump target = {jump_addr, 4'h0}.
REQ-007 dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz.
REQ-008 hold  input  1  stall request; freezes fetch address.
REQ-009 call  input  1  subroutine call (effective only with SEQ_CALL_STACK_EN).
REQ-010 ret  input  1  subroutine return (effective only with SEQ_CALL_STACK_EN).
REQ-011 pm_addr  output  8  combinational program-memory fetch address.
REQ-012 pc  output  8  registered program counter, pc <= pm_addr every cycle.
REQ-013 stack_err  output  1  sticky call-stack overflow/underflow flag.
REQ-014 from_PS  output  8  debug: count of redirects taken.

Function
REQ-015 pm_addr SHALL be selected by strict priority: sync_reset -> 8'h00; hold -> pc; jmp -> {jump_addr,4'h0}; jmp_nz & ~dont_jmp -> {jump_addr,4'h0}; call -> {jump_addr,4'h0}; ret -> stack top; otherwise pc + 1.
REQ-016 pc+1 SHALL be 8-bit modulo: pc = 8'hFF increments to 8'h00, no flag.
REQ-017 jmp_nz with dont_jmp = 1 SHALL fall through to lower-priority sources (call, ret, increment).
REQ-018 Sequencer SHALL carry a 2-state FSM: RUN (fetch advances) and STALL (entered on a cycle where hold = 1, left on the first cycle hold = 0); redirects arriving during STALL SHALL be ignored, not queued.
REQ-019 Call stack SHALL be 4 entries x 8 bits, LIFO, with 3-bit depth 0..4.
REQ-020 Effective call (REQ-015 selects call) SHALL push pc + 1 (mod 256) and increment depth.
REQ-021 Call at depth 4 SHALL still redirect, SHALL NOT modify the stack, and SHALL set stack_err.
REQ-022 Effective ret at depth >= 1 SHALL drive pm_addr from top entry and decrement depth in the same edge.
REQ-023 Ret at depth 0 SHALL produce pm_addr = pc + 1 and set stack_err.
REQ-024 call and ret asserted together SHALL act as call only.
REQ-025 from_PS SHALL increment (8-bit wrap) on each edge where jmp, taken jmp_nz, call, or successful ret selected pm_addr; hold cycles, untaken jmp_nz, underflow ret SHALL NOT count.
REQ-026 stack_err SHALL remain set until sync_reset.

Reset
REQ-027 While sync_reset = 1: pm_addr = 8'h00 combinationally; on edge pc <= 8'h00, depth <= 0, stack_err <= 0, from_PS <= 8'h00, FSM <= RUN; stack contents need not clear.
REQ-028 sync_reset SHALL override hold, redirects and pending stack operations in the same cycle.
REQ-029 First cycle after reset release SHALL fetch pm_addr = 8'h01 absent other requests.

Configuration
REQ-030 Macro SEQ_CALL_STACK_EN defined: call, ret, stack and stack_err behave per REQ-019..REQ-024.
REQ-031 Macro SEQ_CALL_STACK_EN undefined: call and ret SHALL be ignored, no stack storage SHALL be built, stack_err SHALL be tied 0; all other behaviour unchanged.

Verification
REQ-032 Reset then 3 idle cycles -> pm_addr sequence 00, 01, 02, 03; from_PS = 0.
REQ-033 pc = 8'h25, jmp = 1, jump_addr = 4'hA -> pm_addr = 8'hA0, next pc = 8'hA0, from_PS +1.
REQ-034 pc = 8'h30, jmp_nz = 1, jump_addr = 4'h7, dont_jmp = 1 -> pm_addr = 8'h31; same with dont_jmp = 0 -> 8'h70.
REQ-035 hold = 1 for 3 cycles at pc = 8'h12 with jmp pulsed mid-hold -> pm_addr = 8'h12 throughout; release -> 8'h13, from_PS unchanged.
REQ-036 (SEQ_CALL_STACK_EN) call from pc 8'h10 to page 4, then ret -> pm_addr 8'h40 then 8'h11; 5 nested calls -> stack_err = 1 and 4 rets return correct addresses; ret at depth 0 -> pm_addr = pc + 1, stack_err = 1.
REQ-037 pc = 8'hFF idle -> pm_addr = 8'h00; sync_reset asserted mid-call sequence -> depth 0, stack_err 0, pm_addr 8'h00.
